// File: rtl/pll_rst_seq.sv
// PLL reset sequencer: pulses the PLL reset and waits for a stable lock.
// It retries failed lock attempts up to MAX_RETRY times and then parks in FAULT.
// It releases the downstream datapath reset only while the PLL is locked (RUN).
module pll_rst_seq #(
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_TIMEOUT_CYC = 50000,
    parameter int STABLE_CYC       = 1024,
    parameter int MAX_RETRY        = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       force_relock,
    output logic       pll_reset,
    output logic       sys_rst_out,
    output logic       locked_ok,
    output logic       fault,
    output logic [3:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    // The shared timer must hold the last count of the longest interval.
    localparam int TMR_MAX_A = (RST_PULSE_CYC > LOCK_TIMEOUT_CYC) ? RST_PULSE_CYC : LOCK_TIMEOUT_CYC;
    localparam int TMR_MAX   = (TMR_MAX_A > STABLE_CYC) ? TMR_MAX_A : STABLE_CYC;
    localparam int TMR_W     = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(RST_PULSE_CYC - 1);
    localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] STB_LAST = TMR_W'(STABLE_CYC - 1);

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [TMR_W-1:0] tmr, tmr_nxt;
    logic [3:0]       retry_nxt;
    logic [7:0]       loss_nxt;
    logic             lock_meta, lock_s;
    logic             pll_reset_d, sys_rst_d, locked_ok_d, fault_d;

    // Two-flop synchronizer bringing the asynchronous PLL lock into the clk domain.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
        if (rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    // State register with its timer, counters and next-state-decoded outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RESET_PLL;
            tmr         <= '0;
            retry_cnt   <= 4'd0;
            loss_cnt    <= 8'd0;
            pll_reset   <= 1'b1;
            sys_rst_out <= 1'b1;
            locked_ok   <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= state_nxt;
            tmr         <= tmr_nxt;
            retry_cnt   <= retry_nxt;
            loss_cnt    <= loss_nxt;
            pll_reset   <= pll_reset_d;
            sys_rst_out <= sys_rst_d;
            locked_ok   <= locked_ok_d;
            fault       <= fault_d;
        end
    end

    // Next-state, timer and counter logic; force_relock overrides every other event.
    always_comb begin
        // NOTE: default every comb output first so no path leaves a value held (no latches).
        state_nxt = state;
        tmr_nxt   = tmr;
        retry_nxt = retry_cnt;
        loss_nxt  = loss_cnt;
        if (force_relock) begin
            state_nxt = RESET_PLL;
            tmr_nxt   = '0;
            retry_nxt = 4'd0;
        end else begin
            case (state)
                RESET_PLL: begin
                    if (tmr == RST_LAST) begin
                        state_nxt = WAIT_LOCK;
                        tmr_nxt   = '0;
                    end else begin
                        tmr_nxt = tmr + TMR_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    // Lock is tested first so it wins over a timeout in the same cycle.
                    if (lock_s) begin
                        state_nxt = STABLE;
                        tmr_nxt   = '0;
                    end else if (tmr == TO_LAST) begin
                        tmr_nxt = '0;
                        if (retry_cnt == 4'(MAX_RETRY)) begin
                            state_nxt = FAULT;
                        end else begin
                            state_nxt = RESET_PLL;
                            retry_nxt = retry_cnt + 4'd1;
                        end
                    end else begin
                        tmr_nxt = tmr + TMR_W'(1);
                    end
                end
                STABLE: begin
                    // A lock dropout here is a glitch: go back to waiting without a PLL reset.
                    if (!lock_s) begin
                        state_nxt = WAIT_LOCK;
                        tmr_nxt   = '0;
                    end else if (tmr == STB_LAST) begin
                        state_nxt = RUN;
                        tmr_nxt   = '0;
                    end else begin
                        tmr_nxt = tmr + TMR_W'(1);
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state_nxt = RESET_PLL;
                        tmr_nxt   = '0;
                        retry_nxt = 4'd0;
                        if (loss_cnt != 8'hFF) begin
                            loss_nxt = loss_cnt + 8'd1;
                        end
                    end
                end
                FAULT: begin
                    state_nxt = FAULT;
                end
                default: begin
                    state_nxt = RESET_PLL;
                    tmr_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs decoded from the next state so they switch on the transition edge.
    always_comb begin
        pll_reset_d = (state_nxt == RESET_PLL) || (state_nxt == FAULT);
        sys_rst_d   = (state_nxt != RUN);
        locked_ok_d = (state_nxt == RUN);
        fault_d     = (state_nxt == FAULT);
    end

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed bench for pll_rst_seq with short timing parameters.
module tb_pll_rst_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_lock;
    logic       force_relock;
    logic       pll_reset;
    logic       sys_rst_out;
    logic       locked_ok;
    logic       fault;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;

    int errors = 0;
    int checks = 0;

    pll_rst_seq #(
        .RST_PULSE_CYC   (4),
        .LOCK_TIMEOUT_CYC(100),
        .STABLE_CYC      (8),
        .MAX_RETRY       (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pll_lock    (pll_lock),
        .force_relock(force_relock),
        .pll_reset   (pll_reset),
        .sys_rst_out (sys_rst_out),
        .locked_ok   (locked_ok),
        .fault       (fault),
        .retry_cnt   (retry_cnt),
        .loss_cnt    (loss_cnt)
    );

    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst          = 1'b1;
        pll_lock     = 1'b0;
        force_relock = 1'b0;

        // Reset state.
        tick(3);
        check("rst_pll_reset", pll_reset, 1);
        check("rst_sys_rst", sys_rst_out, 1);
        check("rst_locked_ok", locked_ok, 0);
        check("rst_fault", fault, 0);
        check("rst_retry", retry_cnt, 0);
        check("rst_loss", loss_cnt, 0);

        // Nominal start: release at T0, lock at T20, RUN at T31.
        rst = 1'b0;
        tick(3);
        check("nom_pulse_t3", pll_reset, 1);
        tick(1);
        check("nom_pulse_t4", pll_reset, 0);
        tick(16);
        pll_lock = 1'b1;
        tick(10);
        check("nom_sys_rst_t10", sys_rst_out, 1);
        tick(1);
        check("nom_sys_rst_t11", sys_rst_out, 0);
        check("nom_locked_ok", locked_ok, 1);
        check("nom_retry", retry_cnt, 0);
        check("nom_pll_reset", pll_reset, 0);

        // force_relock in RUN: 4-cycle PLL reset pulse, loss count unchanged.
        force_relock = 1'b1;
        tick(1);
        force_relock = 1'b0;
        check("frc_run_pll_reset", pll_reset, 1);
        check("frc_run_sys_rst", sys_rst_out, 1);
        check("frc_run_locked_ok", locked_ok, 0);
        tick(3);
        check("frc_run_pulse_end", pll_reset, 1);
        tick(1);
        check("frc_run_pulse_off", pll_reset, 0);
        tick(8);
        check("frc_run_stable", locked_ok, 0);
        tick(1);
        check("frc_run_relock", locked_ok, 1);
        check("frc_run_loss", loss_cnt, 0);

        // Reset from RUN aborts, then lock glitch while STABLE.
        rst      = 1'b1;
        pll_lock = 1'b0;
        tick(2);
        check("rst2_sys_rst", sys_rst_out, 1);
        check("rst2_pll_reset", pll_reset, 1);
        check("rst2_locked_ok", locked_ok, 0);
        rst = 1'b0;
        tick(3);
        check("rst2_pulse_t3", pll_reset, 1);
        tick(1);
        check("rst2_pulse_t4", pll_reset, 0);
        tick(16);
        pll_lock = 1'b1;
        for (int c = 21; c <= 38; c++) begin
            tick(1);
            if (c == 25) pll_lock = 1'b0;
            if (c == 28) pll_lock = 1'b1;
            check("glitch_no_pulse", {pll_reset, sys_rst_out}, 2'b01);
        end
        tick(1);
        check("glitch_release", sys_rst_out, 0);
        check("glitch_retry", retry_cnt, 0);

        // Lock loss in RUN, repeated until the loss counter saturates.
        for (int i = 1; i <= 300; i++) begin
            pll_lock = 1'b0;
            tick(2);
            if (i == 1) check("loss_t2_sys_rst", sys_rst_out, 0);
            tick(1);
            if (i == 1) begin
                check("loss_t3_sys_rst", sys_rst_out, 1);
                check("loss_t3_pll_reset", pll_reset, 1);
                check("loss_t3_cnt", loss_cnt, 1);
            end
            pll_lock = 1'b1;
            tick(13);
            check("loss_cnt", loss_cnt, (i > 255) ? 255 : i);
            if (i == 300) check("loss_relock", locked_ok, 1);
        end

        // Retry exhaustion with the lock held low.
        rst      = 1'b1;
        pll_lock = 1'b0;
        tick(2);
        check("rst3_loss", loss_cnt, 0);
        rst = 1'b0;
        tick(3);
        check("ex_p1_on", pll_reset, 1);
        check("ex_retry0", retry_cnt, 0);
        tick(1);
        check("ex_p1_off", pll_reset, 0);
        tick(99);
        check("ex_to1_before", {pll_reset, retry_cnt}, {1'b0, 4'd0});
        tick(1);
        check("ex_p2_on", {pll_reset, retry_cnt}, {1'b1, 4'd1});
        tick(3);
        check("ex_p2_hold", pll_reset, 1);
        tick(1);
        check("ex_p2_off", pll_reset, 0);
        tick(99);
        check("ex_to2_before", {pll_reset, retry_cnt}, {1'b0, 4'd1});
        tick(1);
        check("ex_p3_on", {pll_reset, retry_cnt}, {1'b1, 4'd2});
        tick(4);
        check("ex_p3_off", pll_reset, 0);
        tick(99);
        check("ex_to3_before", {fault, pll_reset}, 2'b00);
        tick(1);
        check("ex_fault", fault, 1);
        check("ex_fault_pll_reset", pll_reset, 1);
        check("ex_fault_retry", retry_cnt, 2);
        check("ex_fault_sys_rst", sys_rst_out, 1);
        tick(500);
        check("ex_hold_fault", {fault, pll_reset, locked_ok, retry_cnt}, {3'b110, 4'd2});

        // force_relock in FAULT in the same cycle the lock rises.
        force_relock = 1'b1;
        pll_lock     = 1'b1;
        tick(1);
        force_relock = 1'b0;
        check("frc_flt_fault", fault, 0);
        check("frc_flt_pll_reset", pll_reset, 1);
        check("frc_flt_retry", retry_cnt, 0);
        tick(3);
        check("frc_flt_pulse_end", pll_reset, 1);
        tick(1);
        check("frc_flt_pulse_off", pll_reset, 0);
        tick(8);
        check("frc_flt_stable", locked_ok, 0);
        tick(1);
        check("frc_flt_run", locked_ok, 1);

        // Lock arriving in the timeout cycle wins over the retry.
        rst      = 1'b1;
        pll_lock = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(101);
        pll_lock = 1'b1;
        tick(3);
        check("tie_no_retry", {pll_reset, retry_cnt}, {1'b0, 4'd0});
        check("tie_sys_rst", sys_rst_out, 1);
        tick(8);
        check("tie_run", locked_ok, 1);
        check("tie_retry_run", retry_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pll_rst_seq.md
PLL_RST_SEQ -- requirements
Module: pll_rst_seq

Interface
REQ-001 Parameter RST_PULSE_CYC, default 16: number of cycles `pll_reset` is held high per reset attempt.
REQ-002 Parameter LOCK_TIMEOUT_CYC, default 50000: cycles allowed in WAIT_LOCK without lock before an attempt counts as failed (1 ms at 50 MHz).
REQ-003 Parameter STABLE_CYC, default 1024: consecutive cycles of synchronized lock required before downstream reset is released.
REQ-004 Parameter MAX_RETRY, default 7: number of failed attempts tolerated before FAULT; range 0..15.
REQ-005 `clk`  in  1  system clock, the same 50 MHz reference that feeds the PLL `clkin`.
REQ-006 `rst`  in  1  reset; synchronous to `clk`, active-high.
REQ-007 `pll_lock`  in  1  PLL LOCK output; asynchronous to `clk`.
REQ-008 `force_relock`  in  1  single-cycle request to re-run the full sequence.
REQ-009 `pll_reset`  out  1  drives the PLL RESET input; active-high.
REQ-010 `sys_rst_out`  out  1  active-high reset to the PLL-clocked audio datapath.
REQ-011 `locked_ok`  out  1  high only in RUN.
REQ-012 `fault`  out  1  high only in FAULT.
REQ-013 `retry_cnt`  out  4  failed attempts in the current sequence.
REQ-014 `loss_cnt`  out  8  lock-loss events seen in RUN; saturates at 255.

Function
REQ-015 `pll_lock` SHALL pass through a 2-flop synchronizer to give `lock_s`; all decisions SHALL use `lock_s` only.
REQ-016 The FSM SHALL have five states: RESET_PLL, WAIT_LOCK, STABLE, RUN and FAULT, with one shared cycle counter `tmr`.
REQ-017 RESET_PLL: `pll_reset`=1; when `tmr`=RST_PULSE_CYC-1 -> WAIT_LOCK and `tmr`<=0.
REQ-018 WAIT_LOCK: `pll_reset`=0; if `lock_s`=1 -> STABLE and `tmr`<=0.
REQ-019 WAIT_LOCK timeout: if `tmr`=LOCK_TIMEOUT_CYC-1 and `lock_s`=0, then -> FAULT when `retry_cnt`=MAX_RETRY, else `retry_cnt`++ and -> RESET_PLL.
REQ-020 WAIT_LOCK simultaneous events: lock arriving in the timeout cycle SHALL win, i.e. -> STABLE with no retry counted.
REQ-021 STABLE: if `lock_s`=0 -> WAIT_LOCK with `tmr`<=0 (no PLL reset, no retry increment); else if `tmr`=STABLE_CYC-1 -> RUN.
REQ-022 RUN: if `lock_s`=0 -> RESET_PLL, `loss_cnt`++ (saturating), `retry_cnt`<=0.
REQ-023 FAULT: hold until `rst` or `force_relock`; `pll_reset`=1 for the whole time in FAULT, to hold the PLL in reset.
REQ-024 `force_relock`=1 in any state SHALL force -> RESET_PLL with `tmr`<=0 and `retry_cnt`<=0.
REQ-025 `force_relock` SHALL take priority over every lock or timer event in the same cycle.
REQ-026 Outputs SHALL be registered and decoded from the next state, so each output changes in the same edge as the state transition.
REQ-027 `sys_rst_out` SHALL be 1 in every state except RUN.
REQ-028 `tmr` SHALL be wide enough for max(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, STABLE_CYC) and SHALL never wrap inside a state.
REQ-029 Latency from a `pll_lock` rise (already in WAIT_LOCK) to `sys_rst_out` fall SHALL be exactly STABLE_CYC+3 cycles.
REQ-030 Latency from a `pll_lock` fall in RUN to `sys_rst_out` rise SHALL be exactly 3 cycles.

Reset
REQ-031 While `rst`=1: state=RESET_PLL, `tmr`=0, `retry_cnt`=0, `loss_cnt`=0, `pll_reset`=1, `sys_rst_out`=1, `locked_ok`=0, `fault`=0, synchronizer flops=0.
REQ-032 `rst` asserted mid-sequence (any state, including FAULT) SHALL abort the sequence; after release `pll_reset` SHALL stay high for exactly RST_PULSE_CYC further cycles.

Verification
Use RST_PULSE_CYC=4, LOCK_TIMEOUT_CYC=100, STABLE_CYC=8, MAX_RETRY=2 for all scenarios.
REQ-033 Nominal start: release `rst`, raise `pll_lock` 20 cycles later -> `pll_reset` high exactly 4 cycles after release; `sys_rst_out` falls 11 cycles after the lock rise; `locked_ok`=1, `retry_cnt`=0.
REQ-034 Lock glitch in STABLE: `pll_lock` low for 3 cycles after 5 stable cycles -> no `pll_reset` pulse; `sys_rst_out` falls 11 cycles after the second lock rise.
REQ-035 Retry exhaustion: `pll_lock` held 0 -> three 4-cycle `pll_reset` pulses, `retry_cnt` steps 0,1,2, then `fault`=1 and `pll_reset`=1 after the third timeout; hold 500 cycles -> state unchanged.
REQ-036 Loss in RUN: drop `pll_lock` -> `sys_rst_out`=1 and `pll_reset`=1 3 cycles later, `loss_cnt`=1; re-lock -> RUN again; repeat 300 times -> `loss_cnt`=255.
REQ-037 Priority: `force_relock` in FAULT in the same cycle `pll_lock` rises -> RESET_PLL, `retry_cnt`=0, `fault`=0 next cycle; a `force_relock` pulse in RUN -> 4-cycle `pll_reset` pulse with `loss_cnt` unchanged.
